// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide unit. One shared add/subtract
//               datapath is stepped 32 times (shift-add multiply, restoring
//               divide), then a fix-up cycle applies sign correction and
//               registers the result alongside a one-cycle done pulse.
//               Optional feature macro: MULDIV_SIGNED_EN (signed RV32M ops).
//               Without it, signed ops alias to their unsigned forms.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0]       c_MUL    = 3'b000;
  localparam logic [2:0]       c_MULH   = 3'b001;
  localparam logic [2:0]       c_MULHSU = 3'b010;
  localparam logic [2:0]       c_DIV    = 3'b100;
  localparam logic [2:0]       c_REM    = 3'b110;
  localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_hi;      // product high word / partial remainder
  logic [XLEN-1:0]   r_lo;      // product low word / dividend -> quotient
  logic [XLEN-1:0]   r_b;       // multiplicand / divisor magnitude
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_accept;
  logic              w_is_div;
  logic [XLEN:0]     w_shift;
  logic [XLEN+1:0]   w_op_a;
  logic [XLEN+1:0]   w_sum;
  logic              w_trial_ok;
  logic [XLEN:0]     w_mul_hi;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_is_div = r_funct3[2];

  // Single shared adder: divide subtracts the divisor from the shifted
  // remainder, multiply adds the multiplicand to the running high word.
  assign w_shift    = {r_hi, r_lo[XLEN-1]};
  assign w_op_a     = w_is_div ? {1'b0, w_shift} : {2'b00, r_hi};
  assign w_sum      = w_is_div ? (w_op_a - {2'b00, r_b}) : (w_op_a + {2'b00, r_b});
  assign w_trial_ok = !w_sum[XLEN+1];
  assign w_mul_hi   = r_lo[0] ? w_sum[XLEN:0] : {1'b0, r_hi};

`ifdef MULDIV_SIGNED_EN
  logic r_a_neg;
  logic r_b_neg;
  logic r_b_zero;
  logic w_a_signed;
  logic w_b_signed;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_signed = (funct3_i == c_MULH) || (funct3_i == c_MULHSU) ||
                      (funct3_i == c_DIV)  || (funct3_i == c_REM);
  assign w_b_signed = (funct3_i == c_MULH) || (funct3_i == c_DIV) ||
                      (funct3_i == c_REM);
  assign w_a_neg    = w_a_signed && a_i[XLEN-1];
  assign w_b_neg    = w_b_signed && b_i[XLEN-1];
  assign w_a_abs    = w_a_neg ? (~a_i + 1'b1) : a_i;
  assign w_b_abs    = w_b_neg ? (~b_i + 1'b1) : b_i;

  // Sign flags captured with the operands, consumed in the fix-up cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      r_b_zero <= (b_i == '0);
    end
  end

  // Divide-by-zero leaves the all-ones quotient untouched; the remainder
  // fix restores the original dividend from its magnitude.
  assign w_prod = (r_a_neg ^ r_b_neg) ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quot = ((r_a_neg ^ r_b_neg) && !r_b_zero) ? (~r_lo + 1'b1) : r_lo;
  assign w_rem  = r_a_neg ? (~r_hi + 1'b1) : r_hi;
`else
  assign w_a_abs = a_i;
  assign w_b_abs = b_i;
  assign w_prod  = {r_hi, r_lo};
  assign w_quot  = r_lo;
  assign w_rem   = r_hi;
`endif

  // Output word selection for the fix-up cycle.
  always_comb begin
    w_result = w_prod[2*XLEN-1:XLEN];
    if (w_is_div) begin
      w_result = r_funct3[1] ? w_rem : w_quot;
    end else if (r_funct3 == c_MUL) begin
      w_result = w_prod[XLEN-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every transition, including a start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == c_LAST) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_next = S_IDLE;
    end
  end

  // Operand capture and one multiply/divide iteration per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_funct3 <= funct3_i;
      r_hi     <= '0;
      r_lo     <= w_a_abs;
      r_b      <= w_b_abs;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_is_div) begin
        r_hi <= w_trial_ok ? w_sum[XLEN-1:0] : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_trial_ok};
      end else begin
        r_hi <= w_mul_hi[XLEN:1];
        r_lo <= {w_mul_hi[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // Result register and done pulse; a flush suppresses both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_FIX) && !flush_i) begin
        r_result <= w_result;
        r_done   <= 1'b1;
      end
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Results are checked
//               against an arithmetic reference of the RV32M rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_tests;
  int n_fail;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [2:0]         op;
    logic signed [63:0] p;
    logic [63:0]        pu;
    logic [31:0]        r;
    op = f3;
`ifndef MULDIV_SIGNED_EN
    if (op == 3'd1 || op == 3'd2) op = 3'd3;
    else if (op == 3'd4) op = 3'd5;
    else if (op == 3'd6) op = 3'd7;
`endif
    r = '0;
    case (op)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drives a request at a falling edge; returns just after the accepting edge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start_i  = 1'b1;
    funct3_i = f3;
    a_i      = a;
    b_i      = b;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Waits (bounded) for done_o; lat is the edge index after the accepting edge.
  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cnt,
                           output bit got);
    got = 1'b0; lat = -1; busy_cnt = 0; res = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        got = 1'b1; lat = i; res = result_o;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_tests++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_tests++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mulhu_latency();
    logic [31:0] res; int lat; int bc; bit got;
    launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(res, lat, bc, got);
    n_tests++;
    if (!got || res !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL t1_result got=%h done=%b exp=fffffffe", res, got);
    end
    n_tests++;
    if (lat !== 33) begin n_fail++; $display("FAIL t1_latency got=%0d exp=33", lat); end
    n_tests++;
    if (bc !== 33) begin n_fail++; $display("FAIL t1_busy_cycles got=%0d exp=33", bc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; int bc; bit got;
    launch(3'b101, 32'd100, 32'd7);
    wait_done(res, lat, bc, got);
    n_tests++;
    if (!got || res !== 32'd14) begin n_fail++; $display("FAIL t2_divu got=%h exp=0000000e", res); end
    // Still in the done cycle: the new request must be accepted immediately.
    launch(3'b111, 32'd100, 32'd7);
    wait_done(res, lat, bc, got);
    n_tests++;
    if (!got || res !== 32'd2) begin n_fail++; $display("FAIL t2_remu got=%h exp=00000002", res); end
    n_tests++;
    if (lat !== 33 || bc !== 33) begin
      n_fail++; $display("FAIL t2_no_gap latency=%0d busy=%0d exp=33/33", lat, bc);
    end
    @(negedge clk);
  endtask

  task automatic test_div_corner();
    logic [31:0] res; int lat; int bc; bit got;
    logic [2:0]  f3s [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] exps[4];
    exps[0] = 32'hFFFF_FFFF; exps[1] = 32'h1234_5678;
    exps[2] = model(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    exps[3] = model(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
    n_tests++;
    if (exps[2] !== 32'h8000_0000 || exps[3] !== 32'h0) begin
      n_fail++; $display("FAIL t3_model_overflow got=%h/%h exp=80000000/0", exps[2], exps[3]);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < 2) launch(f3s[i], 32'h1234_5678, 32'h0);
      else launch(f3s[i], 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(res, lat, bc, got);
      n_tests++;
      if (!got || res !== exps[i]) begin
        n_fail++; $display("FAIL t3_div_corner_%0d got=%h exp=%h", i, res, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed_ops();
    logic [31:0] res; int lat; int bc; bit got;
    logic [2:0]  f3s [3] = '{3'b001, 3'b100, 3'b110};
    logic [31:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bs  [3] = '{32'd5, 32'd2, 32'd2};
`ifdef MULDIV_SIGNED_EN
    logic [31:0] exps[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
`else
    logic [31:0] exps[3] = '{32'h0000_0004, 32'h7FFF_FFFC, 32'h0000_0001};
`endif
    for (int i = 0; i < 3; i++) begin
      launch(f3s[i], as[i], bs[i]);
      wait_done(res, lat, bc, got);
      n_tests++;
      if (!got || res !== exps[i]) begin
        n_fail++; $display("FAIL t4_signed_%0d got=%h exp=%h", i, res, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] res; int lat; int bc; bit got;
    logic [2:0]  f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      exp = model(f3, a, b);
      launch(f3, a, b);
      wait_done(res, lat, bc, got);
      n_tests++;
      if (!got || res !== exp || lat !== 33) begin
        n_fail++;
        $display("FAIL rand_%0d f3=%0d a=%h b=%h got=%h lat=%0d exp=%h", i, f3, a, b, res, lat, exp);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; int bc; bit got; logic [31:0] prev; bit saw_done;
    prev = result_o;
    launch(3'b000, 32'd6, 32'd7);
    repeat (10) @(posedge clk);   // counter is 10 after this edge
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL t5_flush_busy got=%b exp=0", busy_o); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_done) begin n_fail++; $display("FAIL t5_flush_done got=1 exp=0"); end
    n_tests++;
    if (result_o !== prev) begin n_fail++; $display("FAIL t5_flush_hold got=%h exp=%h", result_o, prev); end
    // Flush and start together in IDLE: flush wins.
    flush_i = 1'b1;
    launch(3'b000, 32'd9, 32'd9);
    flush_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL t5_flush_wins got=%b exp=0", busy_o); end
    launch(3'b000, 32'd6, 32'd7);
    wait_done(res, lat, bc, got);
    n_tests++;
    if (!got || res !== 32'd42) begin n_fail++; $display("FAIL t5_mul_after got=%h exp=0000002a", res); end
    @(negedge clk);
  endtask

  task automatic test_reset_and_ignore();
    logic [31:0] res; int lat; int bc; bit got;
    launch(3'b000, 32'd123, 32'd456);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL t6_async_reset busy=%b done=%b result=%h exp=0/0/0", busy_o, done_o, result_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch(3'b101, 32'd1000, 32'd10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; a_i = $urandom; b_i = $urandom;
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_done(res, lat, bc, got);
    n_tests++;
    if (!got || res !== 32'd100) begin n_fail++; $display("FAIL t6_ignore_start got=%h exp=00000064", res); end
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL t6_no_queue busy=%b exp=0", busy_o); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_mulhu_latency();
    test_back_to_back();
    test_div_corner();
    test_signed_ops();
    test_random();
    test_flush();
    test_reset_and_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
